// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: in-order pipe port plus a FIFO-buffered
// long-latency port, with bounded starvation and a pending-destination mask.
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic [4:0]               p0_rd,
    input  logic [XLEN-1:0]          p0_data,
    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic [4:0]               p1_rd,
    input  logic [XLEN-1:0]          p1_data,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        PIPE_PRI,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [4:0]        fifo_rd_q [DEPTH];
    logic [4:0]        fifo_rd_d [DEPTH];
    logic [XLEN-1:0]   fifo_data_q [DEPTH];
    logic [XLEN-1:0]   fifo_data_d [DEPTH];
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    logic              empty;
    logic              push;
    logic              pop;
    logic [4:0]        head_rd;
    logic [XLEN-1:0]   head_data;

    assign empty     = (count_q == '0);
    assign p1_ready  = (count_q != CW'(DEPTH));
    assign push      = p1_valid && p1_ready;
    assign head_rd   = fifo_rd_q[rptr_q];
    assign head_data = fifo_data_q[rptr_q];

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        pop        = 1'b0;
        p0_ready   = 1'b1;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        unique case (state_q)
            PIPE_PRI: begin
                if (p0_valid && p0_rd != 5'd0) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = p0_rd;
                    rf_wdata_d = p0_data;
                    starve_d   = empty ? 4'd0 : starve_q + 4'd1;
                end else begin
                    pop      = !empty;
                    starve_d = 4'd0;
                end
                if (!empty && starve_d >= 4'(STARVE_MAX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                p0_ready = 1'b0;
                pop      = !empty;
                starve_d = 4'd0;
                state_d  = PIPE_PRI;
            end
        endcase
        // x0 heads are dropped on pop and never reach the write port
        if (pop && head_rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_rd;
            rf_wdata_d = head_data;
        end
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_rd_d[wptr_q]   = p1_rd;
            fifo_data_d[wptr_q] = p1_data;
        end
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pend_mask[fifo_rd_q[rptr_q + AW'(i)]] = 1'b1;
            end
        end
        if (rf_we_q) begin
            pend_mask[rf_waddr_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PIPE_PRI;
            starve_q   <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a random
// run compared against a queue-based writeback model.
module tb_rf_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            p0_valid, p0_ready;
    logic [4:0]      p0_rd;
    logic [XLEN-1:0] p0_data;
    logic            p1_valid, p1_ready;
    logic [4:0]      p1_rd;
    logic [XLEN-1:0] p1_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pend_mask;
    logic [CW-1:0]   fifo_count;

    int checks   = 0;
    int failures = 0;

    rf_wb_arbiter #(
        .XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready),
        .p0_rd(p0_rd), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p1_rd(p1_rd), .p1_data(p1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: queued p1 entries, pipe-grant streak, forced-slot flag
    logic [4:0]      q_rd[$];
    logic [XLEN-1:0] q_data[$];
    bit              m_forced;
    int              m_streak;
    bit              m_we;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;

    bit obs_p0r, obs_p1r, exp_p0r, exp_p1r;

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        foreach (q_rd[i]) if (q_rd[i] != 5'd0) m[q_rd[i]] = 1'b1;
        if (m_we) m[m_waddr] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q_rd.delete();
        q_data.delete();
        m_forced = 0;
        m_streak = 0;
        m_we     = 0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    task automatic tick(input bit p0v, input logic [4:0] p0r,
                        input logic [XLEN-1:0] p0d, input bit p1v,
                        input logic [4:0] p1r, input logic [XLEN-1:0] p1d);
        bit win, had;
        logic [4:0] hr;
        logic [XLEN-1:0] hd;
        p0_valid = p0v; p0_rd = p0r; p0_data = p0d;
        p1_valid = p1v; p1_rd = p1r; p1_data = p1d;
        #1;
        obs_p0r = p0_ready;
        obs_p1r = p1_ready;
        exp_p0r = !m_forced;
        exp_p1r = q_rd.size() < DEPTH;
        had = q_rd.size() > 0;
        win = 0;
        if (m_forced) begin
            m_forced = 0;
            m_streak = 0;
            if (had) begin
                hr = q_rd.pop_front(); hd = q_data.pop_front();
                if (hr != 0) begin win = 1; m_waddr = hr; m_wdata = hd; end
            end
        end else begin
            if (p0v && p0r != 0) begin
                win = 1; m_waddr = p0r; m_wdata = p0d;
                m_streak = had ? m_streak + 1 : 0;
            end else begin
                m_streak = 0;
                if (had) begin
                    hr = q_rd.pop_front(); hd = q_data.pop_front();
                    if (hr != 0) begin win = 1; m_waddr = hr; m_wdata = hd; end
                end
            end
            if (had && m_streak >= STARVE_MAX) m_forced = 1;
        end
        if (p1v && exp_p1r) begin
            q_rd.push_back(p1r);
            q_data.push_back(p1d);
        end
        m_we = win;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_reset();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
            failures++;
            $display("FAIL reset_out: we=%b addr=%0d data=%h want 0/0/0",
                     rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (fifo_count !== '0 || pend_mask !== '0) begin
            failures++;
            $display("FAIL reset_fifo: cnt=%0d mask=%h want 0/0",
                     fifo_count, pend_mask);
        end
        checks++;
        if (p0_ready !== 1'b1 || p1_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: p0r=%b p1r=%b want 1/1", p0_ready, p1_ready);
        end
        tick(1, 5'd1, 32'hA1, 1, 5'd10, 32'hB0);
        tick(1, 5'd2, 32'hA2, 1, 5'd11, 32'hB1);
        checks++;
        if (fifo_count !== CW'(2) || rf_we !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill: cnt=%0d we=%b want 2/1", fifo_count, rf_we);
        end
        #2 rst = 1'b1;
        p0_valid = 0; p1_valid = 0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || fifo_count !== '0 || pend_mask !== '0) begin
            failures++;
            $display("FAIL reset_async: we=%b cnt=%0d mask=%h want 0/0/0",
                     rf_we, fifo_count, pend_mask);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (p1_ready !== 1'b1 || p0_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: p0r=%b p1r=%b want 1/1", p0_ready, p1_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_p0_only();
        tick(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL p0_write: we=%b addr=%0d data=%h want 1/5/deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (pend_mask !== 32'h20) begin
            failures++;
            $display("FAIL p0_mask: got %h want 00000020", pend_mask);
        end
        tick(1, 5'd0, 32'h12345678, 0, '0, '0);
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL p0_x0: we=%b addr=%0d data=%h want 0/5/deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (pend_mask !== '0) begin
            failures++;
            $display("FAIL p0_x0_mask: got %h want 0", pend_mask);
        end
    endtask

    task automatic test_p1_latency();
        tick(0, '0, '0, 1, 5'd7, 32'h11);
        checks++;
        if (rf_we !== 1'b0 || fifo_count !== CW'(1) || pend_mask !== 32'h80) begin
            failures++;
            $display("FAIL p1_accept: we=%b cnt=%0d mask=%h want 0/1/80",
                     rf_we, fifo_count, pend_mask);
        end
        tick(0, '0, '0, 1, 5'd8, 32'h22);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11
            || pend_mask !== 32'h180) begin
            failures++;
            $display("FAIL p1_first: we=%b addr=%0d data=%h mask=%h want 1/7/11/180",
                     rf_we, rf_waddr, rf_wdata, pend_mask);
        end
        tick(0, '0, '0, 0, '0, '0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h22
            || pend_mask !== 32'h100) begin
            failures++;
            $display("FAIL p1_second: we=%b addr=%0d data=%h mask=%h want 1/8/22/100",
                     rf_we, rf_waddr, rf_wdata, pend_mask);
        end
        tick(0, '0, '0, 0, '0, '0);
        checks++;
        if (rf_we !== 1'b0 || pend_mask !== '0 || fifo_count !== '0) begin
            failures++;
            $display("FAIL p1_done: we=%b mask=%h cnt=%0d want 0/0/0",
                     rf_we, pend_mask, fifo_count);
        end
    endtask

    task automatic test_starvation();
        int exp_seq[7] = '{1, 2, 3, 4, 9, 5, 6};
        int seq[$];
        int k = 1;
        int stalls = 0;
        bit v;
        tick(0, '0, '0, 1, 5'd9, 32'h99);
        for (int c = 0; c < 10; c++) begin
            v = (k <= 6);
            tick(v, 5'(k), 32'h100 + k, 0, '0, '0);
            checks++;
            if (obs_p0r !== exp_p0r) begin
                failures++;
                $display("FAIL starve_ready: cyc=%0d got %b want %b", c, obs_p0r, exp_p0r);
            end
            if (v && !obs_p0r) stalls++;
            if (v && obs_p0r) k++;
            if (rf_we) seq.push_back(int'(rf_waddr));
        end
        checks++;
        if (stalls != 1) begin
            failures++;
            $display("FAIL starve_stalls: got %0d want 1", stalls);
        end
        checks++;
        if (seq.size() != 7) begin
            failures++;
            $display("FAIL starve_count: got %0d writes want 7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (seq[i] != exp_seq[i]) begin
                    failures++;
                    $display("FAIL starve_order[%0d]: got x%0d want x%0d",
                             i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_full_fifo();
        int j = 0;
        int p0k = 0;
        bit blocked = 0;
        int got[$];
        bit v1;
        for (int c = 0; c < 40; c++) begin
            v1 = (j < 3);
            tick(1, 5'(1 + p0k % 15), 32'h300 + p0k, v1, 5'(20 + j), 32'h200 + j);
            checks++;
            if (obs_p1r !== exp_p1r) begin
                failures++;
                $display("FAIL full_p1ready: cyc=%0d got %b want %b", c, obs_p1r, exp_p1r);
            end
            if (v1 && !obs_p1r && j == 2) blocked = 1;
            if (v1 && obs_p1r) j++;
            if (obs_p0r) p0k++;
            checks++;
            if (fifo_count > CW'(2) || fifo_count !== CW'(q_rd.size())) begin
                failures++;
                $display("FAIL full_count: cyc=%0d got %0d want %0d",
                         c, fifo_count, q_rd.size());
            end
            if (rf_we && rf_waddr >= 5'd20) begin
                got.push_back(int'(rf_waddr));
                checks++;
                if (rf_wdata !== 32'h200 + (int'(rf_waddr) - 20)) begin
                    failures++;
                    $display("FAIL full_data: x%0d got %h want %h", rf_waddr,
                             rf_wdata, 32'h200 + (int'(rf_waddr) - 20));
                end
            end
        end
        idle(4);
        checks++;
        if (!blocked) begin
            failures++;
            $display("FAIL full_block: got blocked=0 want 1");
        end
        checks++;
        if (got.size() != 3 || got[0] != 20 || got[1] != 21 || got[2] != 22) begin
            failures++;
            $display("FAIL full_order: got %0d writes %p want 20,21,22", got.size(), got);
        end
    endtask

    task automatic test_hazard();
        tick(1, 5'd4, 32'h44, 1, 5'd3, 32'h33);
        checks++;
        if (pend_mask !== 32'h18) begin
            failures++;
            $display("FAIL hz_mask: got %h want 00000018", pend_mask);
        end
        tick(1, 5'd4, 32'h45, 1, 5'd0, 32'hFF);
        checks++;
        if (pend_mask !== 32'h18 || fifo_count !== CW'(2)) begin
            failures++;
            $display("FAIL hz_x0_mask: mask=%h cnt=%0d want 18/2", pend_mask, fifo_count);
        end
        tick(0, '0, '0, 0, '0, '0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || pend_mask !== 32'h8) begin
            failures++;
            $display("FAIL hz_pop3: we=%b addr=%0d mask=%h want 1/3/8",
                     rf_we, rf_waddr, pend_mask);
        end
        tick(0, '0, '0, 0, '0, '0);
        checks++;
        if (rf_we !== 1'b0 || pend_mask !== '0 || fifo_count !== '0) begin
            failures++;
            $display("FAIL hz_popx0: we=%b mask=%h cnt=%0d want 0/0/0",
                     rf_we, pend_mask, fifo_count);
        end
    endtask

    task automatic test_random();
        bit a_v = 0, b_v = 0;
        logic [4:0] a_rd = '0, b_rd = '0;
        logic [XLEN-1:0] a_d = '0, b_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!(a_v && !exp_p0r)) begin
                a_v = ($urandom_range(0, 3) != 0);
                a_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                a_d = $urandom;
            end
            if (!(b_v && !exp_p1r)) begin
                b_v = ($urandom_range(0, 1) != 0);
                b_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                b_d = $urandom;
            end
            tick(a_v, a_rd, a_d, b_v, b_rd, b_d);
            if (a_v && exp_p0r) a_v = 0;
            if (b_v && exp_p1r) b_v = 0;
            checks++;
            if (obs_p0r !== exp_p0r || obs_p1r !== exp_p1r) begin
                failures++;
                $display("FAIL rnd_ready: cyc=%0d got %b%b want %b%b",
                         c, obs_p0r, obs_p1r, exp_p0r, exp_p1r);
            end
            checks++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                failures++;
                $display("FAIL rnd_write: cyc=%0d got %b/%0d/%h want %b/%0d/%h",
                         c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            checks++;
            if (fifo_count !== CW'(q_rd.size()) || pend_mask !== m_mask()) begin
                failures++;
                $display("FAIL rnd_state: cyc=%0d cnt=%0d mask=%h want %0d/%h",
                         c, fifo_count, pend_mask, q_rd.size(), m_mask());
            end
            checks++;
            if (rf_we && rf_waddr == 5'd0) begin
                failures++;
                $display("FAIL rnd_x0_write: cyc=%0d got we with addr 0 want none", c);
            end
        end
        idle(6);
        checks++;
        if (fifo_count !== '0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rnd_drain: cnt=%0d we=%b want 0/0", fifo_count, rf_we);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        p0_valid = 0; p0_rd = '0; p0_data = '0;
        p1_valid = 0; p1_rd = '0; p1_data = '0;
        model_reset();
        exp_p0r = 1; exp_p1r = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_p0_only();
        test_p1_latency();
        test_starvation();
        idle(3);
        test_full_fifo();
        test_hazard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
